// File: rtl/isa_types.sv
// Shared ISA-level type constants used across the core.
package isa_types;
    localparam int XLEN = 32;
endpackage

// File: rtl/internal_ram.sv
// Word-addressed internal RAM with per-byte write enables and a registered read port.
// Read-during-write to the same word returns the pre-write contents.
module internal_ram
    import isa_types::*;
#(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = XLEN
) (
    input  logic                    clock,
    input  logic                    reset_n,
    input  logic [ADDR_WIDTH-1:0]   address,
    input  logic [DATA_WIDTH/8-1:0] byteena,
    input  logic [DATA_WIDTH-1:0]   data,
    input  logic                    wren,
    output logic [DATA_WIDTH-1:0]   q
);

    localparam int DEPTH = 2**ADDR_WIDTH;
    localparam int LANES = DATA_WIDTH/8;

    logic [DATA_WIDTH-1:0] q_d;
    logic [DATA_WIDTH-1:0] q_q;

    // Each byte lane owns its own storage column so lanes update independently.
    for (genvar l = 0; l < LANES; l++) begin : g_lane
        logic [7:0] mem_q [DEPTH];

        always_ff @(posedge clock or negedge reset_n) begin
            if (!reset_n) begin
                for (int w = 0; w < DEPTH; w++) begin
                    mem_q[w] <= '0;
                end
            end else if (wren && byteena[l]) begin
                mem_q[address] <= data[8*l +: 8];
            end
        end

        assign q_d[8*l +: 8] = mem_q[address];
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;

endmodule

// File: tb/tb_internal_ram.sv
// Self-checking bench for internal_ram: directed scenarios plus randomized traffic
// checked against a word-array reference model.
module tb_internal_ram;

    logic        clock;
    logic        reset_n;
    logic [7:0]  address;
    logic [3:0]  byteena;
    logic [31:0] data;
    logic        wren;
    logic [31:0] q;

    int n_cmp;
    int n_fail;

    logic [31:0] model [256];

    internal_ram #(.ADDR_WIDTH(8), .DATA_WIDTH(32)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .address (address),
        .byteena (byteena),
        .data    (data),
        .wren    (wren),
        .q       (q)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic model_clear();
        for (int i = 0; i < 256; i++) model[i] = 32'h0;
    endtask

    // One clock cycle: drive at the falling edge, sample 1ns after the rising edge.
    // exp is what a 1-cycle-latency read of the pre-write word must return.
    task automatic cycle(input logic [7:0] a, input logic [3:0] be, input logic [31:0] d,
                         input logic we, output logic [31:0] got, output logic [31:0] exp);
        @(negedge clock);
        address = a;
        byteena = be;
        data    = d;
        wren    = we;
        @(posedge clock);
        exp = model[a];
        if (we) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) model[a][8*i +: 8] = d[8*i +: 8];
            end
        end
        #1;
        got = q;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        address = 8'h00;
        byteena = 4'h0;
        data    = 32'h0;
        wren    = 1'b0;
        model_clear();
        #2;
        n_cmp++;
        if (q !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_q: got %h want %h", q, 32'h0);
        end
        repeat (2) @(posedge clock);
        @(negedge clock);
        #2 reset_n = 1'b1;
    endtask

    task automatic test_directed();
        logic [7:0]  ta [12] = '{8'h05, 8'h04, 8'h04, 8'h05, 8'h05, 8'h06, 8'h06, 8'h07, 8'h07, 8'h04, 8'h04, 8'h04};
        logic [3:0]  tb [12] = '{4'h0, 4'hF, 4'h0, 4'h3, 4'h0, 4'h1, 4'h0, 4'hC, 4'h0, 4'hC, 4'h0, 4'h2};
        logic [31:0] td [12] = '{32'h0, 32'h87654321, 32'h0, 32'h87654321, 32'h0, 32'h87654321,
                                 32'h0, 32'h43210000, 32'h0, 32'hFEDC0000, 32'h0, 32'h0000BA00};
        logic        tw [12] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        logic [31:0] tq [12] = '{32'h0, 32'h0, 32'h87654321, 32'h0, 32'h00004321, 32'h0,
                                 32'h00000021, 32'h0, 32'h43210000, 32'h87654321, 32'hFEDC4321, 32'hFEDC4321};
        logic [31:0] got, exp;
        for (int i = 0; i < 12; i++) begin
            cycle(ta[i], tb[i], td[i], tw[i], got, exp);
            n_cmp++;
            if (got !== tq[i]) begin
                n_fail++;
                $display("FAIL directed[%0d] addr %h: got %h want %h", i, ta[i], got, tq[i]);
            end
        end
        cycle(8'h04, 4'h0, 32'hFFFFFFFF, 1'b0, got, exp);
        n_cmp++;
        if (got !== 32'hFEDCBA21) begin
            n_fail++;
            $display("FAIL directed_final: got %h want %h", got, 32'hFEDCBA21);
        end
    endtask

    task automatic test_disabled_lanes();
        logic [31:0] got, exp;
        cycle(8'h09, 4'h0, 32'hDEADBEEF, 1'b1, got, exp);
        cycle(8'h09, 4'hF, 32'h11223344, 1'b0, got, exp);
        cycle(8'h09, 4'h1, 32'h9999995A, 1'b1, got, exp);
        cycle(8'h09, 4'h0, 32'h0, 1'b0, got, exp);
        n_cmp++;
        if (got !== 32'h0000005A) begin
            n_fail++;
            $display("FAIL disabled_lanes: got %h want %h", got, 32'h0000005A);
        end
    endtask

    task automatic test_random();
        logic [31:0] got, exp;
        logic [7:0]  a;
        for (int i = 0; i < 400; i++) begin
            a = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 15));
            cycle(a, 4'($urandom), $urandom, 1'($urandom), got, exp);
            n_cmp++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL random[%0d] addr %h: got %h want %h", i, a, got, exp);
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] got, exp;
        cycle(8'h04, 4'hF, 32'hA5A5A5A5, 1'b1, got, exp);
        cycle(8'h04, 4'h0, 32'h0, 1'b0, got, exp);
        n_cmp++;
        if (got !== 32'hA5A5A5A5) begin
            n_fail++;
            $display("FAIL pre_reset_read: got %h want %h", got, 32'hA5A5A5A5);
        end
        @(negedge clock);
        address = 8'h04;
        byteena = 4'hF;
        data    = 32'h12345678;
        wren    = 1'b1;
        #2 reset_n = 1'b0;
        #1;
        n_cmp++;
        if (q !== 32'h0) begin
            n_fail++;
            $display("FAIL async_reset_q: got %h want %h", q, 32'h0);
        end
        @(posedge clock);
        @(negedge clock);
        wren = 1'b0;
        #2 reset_n = 1'b1;
        model_clear();
        for (int i = 0; i < 3; i++) begin
            cycle(8'(4 + 3 * i), 4'h0, 32'h0, 1'b0, got, exp);
            n_cmp++;
            if (got !== 32'h0) begin
                n_fail++;
                $display("FAIL post_reset_read[%0d]: got %h want %h", i, got, 32'h0);
            end
        end
        cycle(8'h04, 4'h6, 32'h00CAFE00, 1'b1, got, exp);
        cycle(8'h04, 4'h0, 32'h0, 1'b0, got, exp);
        n_cmp++;
        if (got !== 32'h00CAFE00) begin
            n_fail++;
            $display("FAIL post_reset_write: got %h want %h", got, 32'h00CAFE00);
        end
    endtask

    initial begin
        n_cmp  = 0;
        n_fail = 0;
        test_reset();
        test_directed();
        test_disabled_lanes();
        test_random();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
